// File: rtl/hash_table_pkg.sv
// hash_table package: shared hash-table result type and statistics widths.
//   ht_result_t     one lookup result as it travels through the result path
//   HT_STATS_CNT_W  width of every traffic-statistics counter in the hash table
package hash_table;

  localparam int HT_STATS_CNT_W = 32;

  typedef struct packed {
    logic        hit;
    logic [1:0]  dir;
    logic [15:0] key;
    logic [31:0] value;
  } ht_result_t;

endpackage

// File: rtl/ht_res_if.sv
// ht_res_if: valid/ready stream carrying one ht_result_t per beat.
//   master drives valid and result, slave drives ready.
//   A beat transfers on a clock edge where valid && ready.
interface ht_res_if;
  import hash_table::*;

  logic       valid;
  logic       ready;
  ht_result_t result;

  modport master (output valid, output result, input ready);
  modport slave  (input valid, input result, output ready);
endinterface

// File: rtl/ht_res_out_fifo_mem.sv
// ht_res_out_fifo_mem: simple dual-port DEPTH x ht_result_t storage with a
// registered read port.
//   clk_i, rst_i         clock, synchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data  write port
//   rd_en/rd_addr        read request; rd_data is updated on the next edge
//   rd_data              registered read data, cleared by reset
// A read of the address being written in the same cycle returns the new data,
// which lets the owner load an entry the cycle it arrives.
module ht_res_out_fifo_mem
  import hash_table::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  ht_result_t    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output ht_result_t    rd_data
);

  ht_result_t mem_q [DEPTH];
  ht_result_t rd_data_q;

  // NOTE: the array has no reset; only entries that were written are ever read,
  // so clearing it would just cost a reset net on every storage bit.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ht_res_out_fifo.sv
// ht_res_out_fifo: in-order output buffer for hash-table results.
//   clk_i, rst_i    clock, synchronous active-high reset
//   ht_res_in       results from the result mux (slave)
//   ht_res_out      results to the consumer (master), first-word-fall-through
//                   from the registered read port of the storage array
//   used_words_o    stored results, including the one presented on ht_res_out
//   res_in_cnt_o, res_out_cnt_o, max_used_o
//                   traffic statistics, present only when the macro
//                   HT_RES_OUT_FIFO_STATS_EN is defined
// ht_res_in.ready is a register, so the consumer's ready never reaches the mux.
module ht_res_out_fifo
  import hash_table::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ht_res_if.slave       ht_res_in,
  ht_res_if.master      ht_res_out,
`ifdef HT_RES_OUT_FIFO_STATS_EN
  output logic [HT_STATS_CNT_W-1:0] res_in_cnt_o,
  output logic [HT_STATS_CNT_W-1:0] res_out_cnt_o,
  output logic [CW-1:0]             max_used_o,
`endif
  output logic [CW-1:0] used_words_o
);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_nxt;
  logic [CW-1:0] array_cnt;   // entries not yet loaded into the output register
  logic          ready_q;
  logic          out_valid;
  logic          push, pop, load;

  assign out_valid = (count_q != '0);

  always_comb begin
    push      = ht_res_in.valid && ready_q;
    pop       = out_valid && ht_res_out.ready;
    array_cnt = count_q - {{AW{1'b0}}, out_valid};
    // The output register needs a new head when it is empty or being popped;
    // the source is the array, or the word being written when the array is empty.
    load      = (!out_valid || pop) && ((array_cnt != '0) || push);
    count_nxt = count_q;
    if (push && !pop)      count_nxt = count_q + 1'b1;
    else if (pop && !push) count_nxt = count_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_nxt;
      ready_q <= (count_nxt != CW'(DEPTH));
    end
  end

  ht_res_out_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (ht_res_in.result),
    .rd_en   (load),
    .rd_addr (rd_ptr_q),
    .rd_data (ht_res_out.result)
  );

  assign ht_res_in.ready  = ready_q;
  assign ht_res_out.valid = out_valid;
  assign used_words_o     = count_q;

`ifdef HT_RES_OUT_FIFO_STATS_EN
  logic [HT_STATS_CNT_W-1:0] res_in_cnt_q, res_out_cnt_q;
  logic [CW-1:0]             max_used_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_in_cnt_q  <= '0;
      res_out_cnt_q <= '0;
      max_used_q    <= '0;
    end else begin
      if (push) res_in_cnt_q  <= res_in_cnt_q + 1'b1;
      if (pop)  res_out_cnt_q <= res_out_cnt_q + 1'b1;
      if (count_q > max_used_q) max_used_q <= count_q;
    end
  end

  assign res_in_cnt_o  = res_in_cnt_q;
  assign res_out_cnt_o = res_out_cnt_q;
  assign max_used_o    = max_used_q;
`endif

endmodule

// File: doc/ht_res_out_fifo.md
# ht_res_out_fifo

Output buffer for hash-table results, placed directly downstream of the result multiplexer that merges the per-direction result streams. It accepts one `ht_result_t` per cycle over an `ht_res_if` valid/ready handshake and stores up to DEPTH results. It presents them in order on an outgoing `ht_res_if`, so a stalling consumer never back-pressures the mux combinationally. It also reports occupancy and, optionally, traffic statistics.

## Interface
- `DEPTH`, default 8: total result capacity; power of two, ≥ 2.
- `clk_i`  in  1  clock; the only clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `ht_res_in`  `ht_res_if.slave`  `ht_result_t` + valid/ready  results from the mux.
- `ht_res_out`  `ht_res_if.master`  `ht_result_t` + valid/ready  results to the consumer.
- `used_words_o`  out  `$clog2(DEPTH)+1`  number of stored results, including the one presented on the output.
- `res_in_cnt_o`  out  `HT_STATS_CNT_W`  accepted-result count (only with `HT_RES_OUT_FIFO_STATS_EN`).
- `res_out_cnt_o`  out  `HT_STATS_CNT_W`  delivered-result count (only with `HT_RES_OUT_FIFO_STATS_EN`).
- `max_used_o`  out  `$clog2(DEPTH)+1`  peak `used_words_o` since reset (only with `HT_RES_OUT_FIFO_STATS_EN`).

## Operation
- **Push:** `ht_res_in.valid && ht_res_in.ready`. **Pop:** `ht_res_out.valid && ht_res_out.ready`.
- `ht_res_in.ready = (used_words_o != DEPTH)`.
  - It is a function of registered count only and has no path from `ht_res_out.ready`.
- `ht_res_out.valid = (used_words_o != 0)`.
  - `ht_res_out.result` is the oldest stored entry.
  - It is driven from a register: first-word-fall-through through an output register.
- Results leave in exact acceptance order. No field of `ht_result_t` is inspected or modified.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged.
- When not empty, the output register is refilled from the storage array on pop. Storage is a DEPTH-entry circular buffer with wrapping write/read pointers of width `$clog2(DEPTH)`. The head entry may be held in the output register.
- Push while full cannot occur because ready is low. Pop while empty cannot occur because valid is low.
- Full with a simultaneous pop: ready stays low that cycle and a push is accepted the next cycle.
- Empty with a simultaneous push: there is no bypass. The entry is visible next cycle.
- `ht_res_out.result` is stable while `ht_res_out.valid && !ht_res_out.ready`.
- Reset mid-operation: all stored results are discarded, pointers and count are cleared, and there is no output glitch beyond the reset values.

## Timing
- Reset values:
  - `ht_res_out.valid` = 0.
  - `ht_res_in.ready` = 0 during reset, then 1 from the first cycle after reset deasserts.
  - `used_words_o` = 0.
  - all stats = 0.
  - `ht_res_out.result` = 0.
- Latency: a push at cycle N into an empty buffer gives `ht_res_out.valid` = 1 at cycle N+1 with that result.
- Throughput: one push and one pop per cycle sustained at any occupancy between 1 and DEPTH−1.
- `used_words_o` reflects the registered count (after cycle N's update at N+1).

## Configuration
- `HT_RES_OUT_FIFO_STATS_EN` defined: implement the stats registers.
  - `res_in_cnt_o` increments on push and `res_out_cnt_o` increments on pop; both are `HT_STATS_CNT_W` bits and wrap modulo 2^`HT_STATS_CNT_W`.
  - `max_used_o` = max(`max_used_o`, `used_words_o`), updated every cycle.
- `HT_RES_OUT_FIFO_STATS_EN` undefined: the three stats ports are absent and no stats logic is generated. Data-path behaviour is identical.

## Structure
- `ht_result_t` and `ht_res_if` come from the existing `hash_table` package and interface. No new typedef is needed.
- Add `HT_STATS_CNT_W = 32` to the `hash_table` package, shared with future statistics blocks.
- One sub-module: `ht_res_out_fifo_mem`, a simple dual-port DEPTH × `$bits(ht_result_t)` array with registered read.
- Pointer, count and output-register control stay in the top module.

## Test plan
- **Single result:** push one result into an empty buffer at cycle 5 → `ht_res_out.valid` high at cycle 6 with identical result; `used_words_o` 0→1→0 after pop.
- **Fill, no drain:** DEPTH=8, `ht_res_out.ready`=0, push 10 back-to-back results → exactly 8 accepted; `ht_res_in.ready` low from the cycle after the 8th push; `used_words_o`=8; pop order equals push order 0..7.
- **Full with pop:** full buffer, assert `ht_res_out.ready` for 1 cycle with `ht_res_in.valid`=1 → no push that cycle; push accepted next cycle; count returns to 8.
- **Stream with random stalls:** 1000 results with random valid/ready at 50% → all delivered in order with no drop or duplicate; pointers wrap at least 100 times.
- **Reset mid-stream:** 5 results stored, assert `rst_i` for 1 cycle → `ht_res_out.valid`=0, `used_words_o`=0, `ht_res_in.ready`=1 the cycle after release.
- **Stats (macro defined):** preload `res_in_cnt_o` to 0xFFFFFFFF via force, push once → wraps to 0; after the fill test `max_used_o`=8.
